// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - Pong game sequencer: serve delay, scoring, game-over.
// Optional PONG_ATTRACT_EN: auto-restart from GAME_OVER after c_ATTRACT_FRAMES frames.
module pong_game_ctrl #(
    parameter int c_SCORE_WIDTH    = 4,
    parameter int c_SCORE_LIMIT    = 9,
    parameter int c_SERVE_FRAMES   = 60,
    parameter int c_ATTRACT_FRAMES = 300
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst,
    input  logic                     i_VSync,
    input  logic                     i_Game_Start,
    input  logic                     i_P1_Miss,
    input  logic                     i_P2_Miss,
    output logic [2:0]               o_State,
    output logic                     o_Frame_Tick,
    output logic                     o_Ball_Enable,
    output logic                     o_Paddle_Enable,
    output logic [c_SCORE_WIDTH-1:0] o_P1_Score,
    output logic [c_SCORE_WIDTH-1:0] o_P2_Score,
    output logic                     o_Game_Over,
    output logic                     o_Winner
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_RUNNING   = 3'd2,
        ST_POINT     = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    localparam int CNT_MAX = (c_SERVE_FRAMES > c_ATTRACT_FRAMES) ? c_SERVE_FRAMES : c_ATTRACT_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]         SERVE_LAST = CNT_W'(c_SERVE_FRAMES - 1);
    localparam logic [c_SCORE_WIDTH-1:0] LIMIT      = c_SCORE_WIDTH'(c_SCORE_LIMIT);
`ifdef PONG_ATTRACT_EN
    localparam logic [CNT_W-1:0]         ATTRACT_LAST = CNT_W'(c_ATTRACT_FRAMES - 1);
`endif

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [c_SCORE_WIDTH-1:0]   p1_q, p1_d, p2_q, p2_d;
    logic                       win_q, win_d;
    logic                       vsync_q, tick_q;
    logic                       ball_en_q, paddle_en_q, game_over_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        win_d   = win_q;
        case (state_q)
            ST_IDLE: begin
                if (i_Game_Start) begin
                    state_d = ST_SERVE;
                    p1_d    = '0;
                    p2_d    = '0;
                    win_d   = 1'b0;
                end
            end
            ST_SERVE: begin
                if (tick_q) begin
                    if (cnt_q == SERVE_LAST) state_d = ST_RUNNING;
                    else                     cnt_d   = cnt_q + 1'b1;
                end
            end
            ST_RUNNING: begin
                if (i_P1_Miss && i_P2_Miss) begin
                    state_d = ST_SERVE;
                end else if (i_P1_Miss) begin
                    p2_d    = p2_q + 1'b1;
                    state_d = ST_POINT;
                end else if (i_P2_Miss) begin
                    p1_d    = p1_q + 1'b1;
                    state_d = ST_POINT;
                end
            end
            ST_POINT: begin
                if (p1_q == LIMIT || p2_q == LIMIT) begin
                    state_d = ST_GAME_OVER;
                    win_d   = (p2_q == LIMIT);
                end else begin
                    state_d = ST_SERVE;
                end
            end
            ST_GAME_OVER: begin
                if (i_Game_Start) begin
                    state_d = ST_SERVE;
                    p1_d    = '0;
                    p2_d    = '0;
                    win_d   = 1'b0;
`ifdef PONG_ATTRACT_EN
                end else if (tick_q) begin
                    if (cnt_q == ATTRACT_LAST) begin
                        state_d = ST_SERVE;
                        p1_d    = '0;
                        p2_d    = '0;
                        win_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Every state change starts the frame counter afresh for the next timed state.
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            p1_q        <= '0;
            p2_q        <= '0;
            win_q       <= 1'b0;
            vsync_q     <= 1'b1;
            tick_q      <= 1'b0;
            ball_en_q   <= 1'b0;
            paddle_en_q <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            win_q       <= win_d;
            vsync_q     <= i_VSync;
            tick_q      <= i_VSync & ~vsync_q;
            ball_en_q   <= (state_d == ST_RUNNING);
            paddle_en_q <= (state_d == ST_SERVE) || (state_d == ST_RUNNING) || (state_d == ST_POINT);
            game_over_q <= (state_d == ST_GAME_OVER);
        end
    end

    assign o_State         = state_q;
    assign o_Frame_Tick    = tick_q;
    assign o_Ball_Enable   = ball_en_q;
    assign o_Paddle_Enable = paddle_en_q;
    assign o_P1_Score      = p1_q;
    assign o_P2_Score      = p2_q;
    assign o_Game_Over     = game_over_q;
    assign o_Winner        = win_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - Directed bench for pong_game_ctrl (serve, scoring, game-over, attract).
module tb_pong_game_ctrl;

    logic       i_Clk = 1'b0;
    logic       i_Rst = 1'b1;
    logic       i_VSync = 1'b1;
    logic       i_Game_Start = 1'b0;
    logic       i_P1_Miss = 1'b0;
    logic       i_P2_Miss = 1'b0;
    logic [2:0] o_State;
    logic       o_Frame_Tick, o_Ball_Enable, o_Paddle_Enable, o_Game_Over, o_Winner;
    logic [3:0] o_P1_Score, o_P2_Score;

    int total = 0;
    int bad   = 0;

    pong_game_ctrl #(
        .c_SCORE_WIDTH   (4),
        .c_SCORE_LIMIT   (9),
        .c_SERVE_FRAMES  (60),
        .c_ATTRACT_FRAMES(3)
    ) dut (
        .i_Clk          (i_Clk),
        .i_Rst          (i_Rst),
        .i_VSync        (i_VSync),
        .i_Game_Start   (i_Game_Start),
        .i_P1_Miss      (i_P1_Miss),
        .i_P2_Miss      (i_P2_Miss),
        .o_State        (o_State),
        .o_Frame_Tick   (o_Frame_Tick),
        .o_Ball_Enable  (o_Ball_Enable),
        .o_Paddle_Enable(o_Paddle_Enable),
        .o_P1_Score     (o_P1_Score),
        .o_P2_Score     (o_P2_Score),
        .o_Game_Over    (o_Game_Over),
        .o_Winner       (o_Winner)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic frame();
        i_VSync = 1'b1; step(); step();
        i_VSync = 1'b0; step(); step();
    endtask

    task automatic serve_frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic pulse_p1();
        i_P1_Miss = 1'b1; step(); i_P1_Miss = 1'b0;
    endtask

    task automatic pulse_p2();
        i_P2_Miss = 1'b1; step(); i_P2_Miss = 1'b0;
    endtask

    task automatic pulse_start();
        i_Game_Start = 1'b1; step(); i_Game_Start = 1'b0;
    endtask

    initial begin
        // Reset with VSync held high: no tick on release.
        step(); step(); step();
        i_Rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("no_tick_after_reset", o_Frame_Tick, 0);
        end
        check("rst_state", o_State, 0);
        check("rst_ball", o_Ball_Enable, 0);
        check("rst_paddle", o_Paddle_Enable, 0);
        check("rst_p1", o_P1_Score, 0);
        check("rst_p2", o_P2_Score, 0);
        check("rst_gameover", o_Game_Over, 0);
        check("rst_winner", o_Winner, 0);
        i_VSync = 1'b0; step(); step();
        check("no_tick_on_fall", o_Frame_Tick, 0);
        i_VSync = 1'b1; step();
        check("tick_on_rise", o_Frame_Tick, 1);
        step();
        check("tick_one_cycle", o_Frame_Tick, 0);
        i_VSync = 1'b0; step(); step();
        check("idle_no_frames_move", o_State, 0);

        // Start and serve delay.
        pulse_start();
        check("start_state", o_State, 1);
        check("serve_ball", o_Ball_Enable, 0);
        check("serve_paddle", o_Paddle_Enable, 1);
        serve_frames(59);
        check("serve_59", o_State, 1);
        frame();
        check("serve_60_state", o_State, 2);
        check("run_ball", o_Ball_Enable, 1);

        // P2 miss scores for P1.
        i_P2_Miss = 1'b1; step(); i_P2_Miss = 1'b0;
        check("point_state", o_State, 3);
        check("point_p1", o_P1_Score, 1);
        check("point_ball", o_Ball_Enable, 0);
        step();
        check("point_to_serve", o_State, 1);

        // Simultaneous misses: re-serve, no score.
        serve_frames(60);
        check("run2_state", o_State, 2);
        i_P1_Miss = 1'b1; i_P2_Miss = 1'b1; step();
        i_P1_Miss = 1'b0; i_P2_Miss = 1'b0;
        check("both_state", o_State, 1);
        check("both_p1", o_P1_Score, 1);
        check("both_p2", o_P2_Score, 0);

        // Misses and start ignored in SERVE.
        pulse_p1();
        check("serve_miss_ign", o_P2_Score, 0);
        pulse_start();
        check("serve_start_ign", o_State, 1);

        // Run P1 up to 8, then the winning point.
        for (int k = 0; k < 7; k++) begin
            serve_frames(60);
            pulse_p2();
            step();
        end
        check("p1_at_8", o_P1_Score, 8);
        serve_frames(60);
        pulse_p2();
        check("p1_9_point", o_State, 3);
        check("p1_9", o_P1_Score, 9);
        step();
        check("go_state", o_State, 4);
        check("go_flag", o_Game_Over, 1);
        check("go_winner_p1", o_Winner, 0);
        check("go_ball", o_Ball_Enable, 0);
        check("go_paddle", o_Paddle_Enable, 0);
        pulse_p1();
        pulse_p2();
        check("go_miss_p1", o_P1_Score, 9);
        check("go_miss_p2", o_P2_Score, 0);
        check("go_miss_state", o_State, 4);
        pulse_start();
        check("restart_state", o_State, 1);
        check("restart_p1", o_P1_Score, 0);
        check("restart_gameover", o_Game_Over, 0);

        // P2 wins.
        for (int k = 0; k < 8; k++) begin
            serve_frames(60);
            pulse_p1();
            step();
        end
        check("p2_at_8", o_P2_Score, 8);
        serve_frames(60);
        pulse_p1();
        check("p2_9", o_P2_Score, 9);
        step();
        check("go2_state", o_State, 4);
        check("go2_winner_p2", o_Winner, 1);

        // Attract restart versus indefinite GAME_OVER.
        serve_frames(3);
`ifdef PONG_ATTRACT_EN
        check("attract_state", o_State, 1);
        check("attract_p2", o_P2_Score, 0);
        check("attract_winner", o_Winner, 0);
`else
        serve_frames(997);
        check("hold_state", o_State, 4);
        check("hold_p2", o_P2_Score, 9);
        check("hold_winner", o_Winner, 1);
`endif

        // Asynchronous reset mid-game.
        #2 i_Rst = 1'b1;
        #1;
        check("async_rst_state", o_State, 0);
        check("async_rst_p2", o_P2_Score, 0);
        check("async_rst_winner", o_Winner, 0);
        check("async_rst_gameover", o_Game_Over, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
